// File: rtl/spram_bist_pkg.sv
// Shared types and helpers for the SPRAM built-in self-test.
// SPRAM_BIST_INV_PASS_EN adds the inverted-pattern second pass states.
package spram_bist_pkg;

  localparam int ADDR_W = 14;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
`ifdef SPRAM_BIST_INV_PASS_EN
    ,
    WRITE_INV,
    READ_INV,
    DRAIN_INV
`endif
  } state_t;

  // Galois right-shift step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] value);
    return (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/spram_bist_lfsr.sv
// Pattern generator for the SPRAM self-test; a zero seed would lock up,
// so it is replaced by 16'h0001.
module spram_bist_lfsr
  import spram_bist_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] value
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= SEED_EFF;
    end else if (load) begin
      value <= SEED_EFF;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/spram_bist.sv
// SPRAM self-test master: fill 0..LAST_ADDR with an LFSR pattern, read back and compare.
// SPRAM_BIST_INV_PASS_EN adds a second pass with the inverted pattern.
module spram_bist
  import spram_bist_pkg::*;
#(
  parameter int          LAST_ADDR = 16383,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data_in,
  output logic              ram_wren,
  output logic [3:0]        ram_maskwren,
  input  logic [15:0]       ram_data_out,
  output state_t            state
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ADDR);

  logic [ADDR_W-1:0] addr;
  logic [15:0]       lfsr_val;
  logic              lfsr_load, lfsr_adv;
  logic              wr_phase, rd_phase, dr_phase, inv, last_pass;
  state_t            rd_state, dr_state;
  logic              last;
  logic [15:0]       pat;

  // Two-stage expected-word pipeline: stage 1 lines up with ram_data_out.
  logic              rd_v0, rd_v1;
  logic [15:0]       exp0, exp1;
  logic [ADDR_W-1:0] eaddr0, eaddr1;
  logic              mismatch, drain_end;
  logic [15:0]       err_next;

  always_comb begin
    wr_phase  = (state == WRITE);
    rd_phase  = (state == READ);
    dr_phase  = (state == DRAIN);
    inv       = 1'b0;
    last_pass = 1'b1;
    rd_state  = READ;
    dr_state  = DRAIN;
`ifdef SPRAM_BIST_INV_PASS_EN
    if (state == DRAIN) last_pass = 1'b0;
    if (state == WRITE_INV) begin
      wr_phase = 1'b1;
      inv      = 1'b1;
      rd_state = READ_INV;
    end
    if (state == READ_INV) begin
      rd_phase = 1'b1;
      inv      = 1'b1;
      dr_state = DRAIN_INV;
    end
    if (state == DRAIN_INV) dr_phase = 1'b1;
`endif
  end

  assign last      = (addr == LAST_A);
  assign pat       = inv ? ~lfsr_val : lfsr_val;
  assign mismatch  = rd_v1 && (ram_data_out != exp1);
  assign drain_end = !rd_v0 && rd_v1;
  assign err_next  = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
  assign ram_maskwren = {4{ram_wren}};

  always_comb begin
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    if ((state == IDLE || state == DONE) && start) lfsr_load = 1'b1;
    else if (wr_phase && last) lfsr_load = 1'b1;
    else if (wr_phase || rd_phase) lfsr_adv = 1'b1;
    else if (dr_phase) lfsr_load = 1'b1;
  end

  spram_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      err_count   <= '0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      ram_wren    <= 1'b0;
      rd_v0       <= 1'b0;
      rd_v1       <= 1'b0;
      exp0        <= '0;
      exp1        <= '0;
      eaddr0      <= '0;
      eaddr1      <= '0;
    end else begin
      rd_v0  <= 1'b0;
      rd_v1  <= rd_v0;
      exp1   <= exp0;
      eaddr1 <= eaddr0;
      if (mismatch) begin
        err_count <= err_next;
        if (err_count == 16'h0000) fail_addr <= eaddr1;
      end

      if (state == IDLE || state == DONE) begin
        if (start) begin
          state     <= WRITE;
          addr      <= '0;
          done      <= 1'b0;
          pass      <= 1'b0;
          err_count <= '0;
          fail_addr <= '0;
        end
      end else if (wr_phase) begin
        busy        <= 1'b1;
        ram_wren    <= 1'b1;
        ram_addr    <= addr;
        ram_data_in <= pat;
        if (last) begin
          addr  <= '0;
          state <= rd_state;
        end else begin
          addr <= addr + 1'b1;
        end
      end else if (rd_phase) begin
        ram_wren <= 1'b0;
        ram_addr <= addr;
        rd_v0    <= 1'b1;
        exp0     <= pat;
        eaddr0   <= addr;
        if (last) state <= dr_state;
        else addr <= addr + 1'b1;
      end else if (dr_phase && drain_end) begin
        // The last read's compare lands on this edge.
        if (last_pass) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next == 16'h0000);
        end
`ifdef SPRAM_BIST_INV_PASS_EN
        else begin
          state <= WRITE_INV;
          addr  <= '0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_spram_bist.sv
// Bench for spram_bist with LAST_ADDR=3 and a behavioural 1-cycle-latency SPRAM
// that can force selected bits of selected addresses to 1.
module tb_spram_bist;
  import spram_bist_pkg::*;

  localparam int N = 4;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef SPRAM_BIST_INV_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int DONE_EDGE = PASSES * (2 * N + 2);

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, done, pass;
  logic [13:0] fail_addr;
  logic [15:0] err_count;
  logic [13:0] ram_addr;
  logic [15:0] ram_data_in;
  logic        ram_wren;
  logic [3:0]  ram_maskwren;
  logic [15:0] ram_data_out;
  state_t      state;

  int tests = 0;
  int fails = 0;

  spram_bist #(.LAST_ADDR(N - 1), .SEED(SEED)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_addr    (fail_addr),
    .err_count    (err_count),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_wren     (ram_wren),
    .ram_maskwren (ram_maskwren),
    .ram_data_out (ram_data_out),
    .state        (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // behavioural SPRAM with stuck-at-1 fault bits
  logic [15:0] mem [0:16383];
  logic [15:0] fault [0:N-1];
  logic [29:0] wr_log[$];
  int          mask_bad = 0;

  function automatic logic [15:0] fbits(input logic [13:0] a);
    return (a < N) ? fault[a] : 16'h0000;
  endfunction

  always @(posedge clk) begin
    if (ram_maskwren !== {4{ram_wren}}) mask_bad <= mask_bad + 1;
    if (ram_wren === 1'b1) begin
      mem[ram_addr] <= ram_data_in | fbits(ram_addr);
      wr_log.push_back({ram_addr, ram_data_in});
    end
    ram_data_out <= mem[ram_addr];
  end

  // reference model
  logic [29:0] exp_q[$];
  logic [15:0] exp_err;
  logic [13:0] exp_faddr;

  function automatic logic [15:0] step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic build_expect();
    logic [15:0] v, w;
    bit found;
    exp_q.delete();
    exp_err   = 16'h0000;
    exp_faddr = 14'h0000;
    found     = 0;
    for (int p = 0; p < PASSES; p++) begin
      v = SEED;
      for (int a = 0; a < N; a++) begin
        w = (p == 1) ? ~v : v;
        exp_q.push_back({14'(a), w});
        if ((w | fault[a]) != w) begin
          if (!found) exp_faddr = 14'(a);
          found = 1;
          if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        end
        v = step(v);
      end
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < N; a++) fault[a] = 16'h0000;
  endtask

  // driver: start at edge 0, optional extra start pulse at busy_pulse_edge
  task automatic run_once(input int busy_pulse_edge, input string tag);
    int e;
    int done_edge;
    int mb;
    done_edge = -1;
    wr_log.delete();
    mb = mask_bad;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || err_count !== 16'h0) begin
      $display("FAIL %s_edge0: busy=%b done=%b err=%0h, required 0 0 0", tag, busy, done, err_count);
      fails++;
    end
    e = 0;
    while (e < DONE_EDGE + 20 && done_edge < 0) begin
      @(negedge clk);
      start = (e + 1 == busy_pulse_edge);
      @(posedge clk);
      #1;
      e++;
      if (e == 1) begin
        tests++;
        if (busy !== 1'b1) begin
          $display("FAIL %s_busy_edge1: busy=%b, required 1", tag, busy);
          fails++;
        end
      end
      if (done === 1'b1) done_edge = e;
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (done_edge != DONE_EDGE) begin
      $display("FAIL %s_done_edge: done at edge %0d, required %0d", tag, done_edge, DONE_EDGE);
      fails++;
    end
    tests++;
    if (busy !== 1'b0 || ram_wren !== 1'b0) begin
      $display("FAIL %s_idle_after_done: busy=%b wren=%b, required 0 0", tag, busy, ram_wren);
      fails++;
    end
    tests++;
    if (mask_bad != mb) begin
      $display("FAIL %s_maskwren: %0d bad cycles, required 0", tag, mask_bad - mb);
      fails++;
    end
    tests++;
    if (wr_log.size() != exp_q.size()) begin
      $display("FAIL %s_write_count: %0d writes, required %0d", tag, wr_log.size(), exp_q.size());
      fails++;
    end
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      tests++;
      if (wr_log[i] !== exp_q[i]) begin
        $display("FAIL %s_write[%0d]: addr/data %0h/%0h, required %0h/%0h", tag, i,
                 wr_log[i][29:16], wr_log[i][15:0], exp_q[i][29:16], exp_q[i][15:0]);
        fails++;
      end
    end
  endtask

  task automatic check_status(input string tag);
    tests++;
    if (pass !== (exp_err == 16'h0) || err_count !== exp_err || fail_addr !== exp_faddr) begin
      $display("FAIL %s_status: pass=%b err=%0h faddr=%0h, required pass=%b err=%0h faddr=%0h",
               tag, pass, err_count, fail_addr, (exp_err == 16'h0), exp_err, exp_faddr);
      fails++;
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 0 || done !== 0 || pass !== 0 || fail_addr !== 0 || err_count !== 0) begin
      $display("FAIL reset_status: busy=%b done=%b pass=%b faddr=%0h err=%0h, required all 0",
               busy, done, pass, fail_addr, err_count);
      fails++;
    end
    tests++;
    if (ram_addr !== 0 || ram_data_in !== 0 || ram_wren !== 0 || ram_maskwren !== 0) begin
      $display("FAIL reset_ram: addr=%0h din=%0h wren=%b mask=%0h, required all 0",
               ram_addr, ram_data_in, ram_wren, ram_maskwren);
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (state !== IDLE || busy !== 1'b0 || ram_wren !== 1'b0) begin
      $display("FAIL reset_start_dropped: state=%0d busy=%b wren=%b, required IDLE 0 0",
               state, busy, ram_wren);
      fails++;
    end
  endtask

  task automatic test_clean_run();
    logic [15:0] words [0:7];
    words = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h531E, 16'h1D8F, 16'h8EC7, 16'hC763};
    clear_faults();
    build_expect();
    run_once(-1, "clean");
    check_status("clean");
    for (int i = 0; i < PASSES * N && i < wr_log.size(); i++) begin
      tests++;
      if (wr_log[i][15:0] !== words[i] || wr_log[i][29:16] !== 14'(i % N)) begin
        $display("FAIL clean_word[%0d]: %0h@%0h, required %0h@%0h", i,
                 wr_log[i][15:0], wr_log[i][29:16], words[i], i % N);
        fails++;
      end
    end
  endtask

  task automatic test_fixed_faults();
    clear_faults();
    fault[2] = 16'h0001;
    build_expect();
    run_once(-1, "fault_a2");
    tests++;
    if (pass !== 1'b0 || fail_addr !== 14'd2 || err_count !== 16'd1) begin
      $display("FAIL fault_a2_const: pass=%b faddr=%0h err=%0h, required 0 2 1", pass, fail_addr, err_count);
      fails++;
    end
    clear_faults();
    fault[1] = 16'h0001;
    fault[3] = 16'h0001;
    build_expect();
    run_once(-1, "fault_a13");
    tests++;
    if (pass !== 1'b0 || fail_addr !== 14'd1 || err_count !== 16'd2) begin
      $display("FAIL fault_a13_const: pass=%b faddr=%0h err=%0h, required 0 1 2", pass, fail_addr, err_count);
      fails++;
    end
  endtask

  task automatic test_random_faults();
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < N; a++)
        fault[a] = ($urandom_range(0, 1) == 1) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
      build_expect();
      run_once(-1, "random");
      check_status("random");
    end
    clear_faults();
  endtask

  task automatic test_start_while_busy();
    clear_faults();
    build_expect();
    run_once(5, "busy_start");
    check_status("busy_start");
  endtask

  task automatic test_reset_mid_write();
    wr_log.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (state !== IDLE || ram_wren !== 1'b0 || busy !== 0 || done !== 0 || pass !== 0 ||
        err_count !== 0 || fail_addr !== 0) begin
      $display("FAIL midreset_state: state=%0d wren=%b busy=%b done=%b pass=%b err=%0h faddr=%0h, required IDLE and 0s",
               state, ram_wren, busy, done, pass, err_count, fail_addr);
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (wr_log.size() != 2) begin
      $display("FAIL midreset_writes: %0d writes issued, required 2", wr_log.size());
      fails++;
    end
    build_expect();
    run_once(-1, "after_reset");
    check_status("after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_faults();
    test_reset();
    test_clean_run();
    test_fixed_faults();
    test_random_faults();
    test_start_while_busy();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spram_bist.md
# spram_bist

Built-in self-test master for one iCE40UP SB_SPRAM256KA instance. It sits directly upstream of the SPRAM and drives address, data and write-enable. It also sits downstream, consuming DATAOUT to check it. It fills a programmable range with a 16-bit LFSR pattern, reads the range back, and compares each word. It reports pass/fail, the first failing address and an error count, for LED/status logic in the top level.

## Interface
- `LAST_ADDR`, default 16383: last word address tested. Range is 0..LAST_ADDR, at most 16383.
- `SEED`, default 16'hACE1: LFSR seed. Value 0 is illegal; 0 is replaced by 16'h0001.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: one-cycle request to begin a test. Ignored while `busy` is high.
- `busy` out 1: test in progress. Reset value 0.
- `done` out 1: high from test completion until the next accepted `start`. Reset value 0.
- `pass` out 1: valid while `done` is high; 1 when `err_count` is 0. Reset value 0.
- `fail_addr` out 14: address of the first mismatch. Reset value 0.
- `err_count` out 16: number of mismatching words, saturating at 16'hFFFF. Reset value 0.
- `ram_addr` out 14: drives SPRAM ADDRESS. Reset value 0.
- `ram_data_in` out 16: drives SPRAM DATAIN. Reset value 0.
- `ram_wren` out 1: drives SPRAM WREN. Reset value 0.
- `ram_maskwren` out 4: drives SPRAM MASKWREN; equals {4{ram_wren}}. Reset value 0.
- `ram_data_out` in 16: SPRAM DATAOUT. Valid one cycle after a read address is presented.

## Operation
- The LFSR is Galois, right-shift, with taps 16'hB400:
  - next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Word k of a pass uses the seed advanced k times.
- States and transitions:
  - IDLE → WRITE on `start`.
  - WRITE → READ after LAST_ADDR.
  - READ → DRAIN after LAST_ADDR.
  - DRAIN → DONE.
  - DONE → WRITE on `start`.
- WRITE:
  - Drive `ram_addr`, `ram_data_in` = lfsr and `ram_wren`=1.
  - Increment the address and advance the LFSR every cycle.
- READ:
  - Reload the LFSR to SEED on entry.
  - Drive addresses 0..LAST_ADDR with `ram_wren`=0.
  - Pipeline the expected word and address by one stage so each compare lines up with `ram_data_out`.
- Compare (READ cycles 2..N and DRAIN): on mismatch,
  - `err_count` increments, saturating;
  - `fail_addr` is loaded only when `err_count` was 0.
- DRAIN performs the final compare.
- DONE: `busy`=0, `done`=1, `pass`=(err_count==0). The SPRAM is left idle with `ram_wren`=0.
- Accepting `start` in IDLE or DONE clears `done`, `pass`, `err_count` and `fail_addr` on the same edge.
- Reset mid-test: on the next edge all outputs take their reset values and the state returns to IDLE. No further write is issued; the SPRAM contents are left undefined.

## Timing
- N = LAST_ADDR+1.
- `start` sampled at edge 0:
  - first write is presented in cycle 1;
  - writes occupy cycles 1..N;
  - reads occupy cycles N+1..2N;
  - DRAIN is cycle 2N+1;
  - `done` rises at edge 2N+2.
- `busy` rises at edge 1 and falls at the same edge `done` rises.
- LAST_ADDR=0 is legal: one write, one read, `done` at edge 4.
- A `start` pulse coinciding with `rst_n`=0 is dropped.

## Configuration
- `SPRAM_BIST_INV_PASS_EN` defined:
  - After DRAIN, run a second pass, WRITE_INV → READ_INV → DRAIN_INV, using the bitwise-inverted pattern (~lfsr, same seed).
  - Errors from both passes accumulate into one count.
  - `done` rises at edge 4N+4.
- Undefined: single true-pattern pass only, and the INV states do not exist.

## Structure
- Package `spram_bist_pkg` holds:
  - the state enum;
  - `LFSR_TAPS` = 16'hB400;
  - the `lfsr_next` function;
  - the address width constant 14.
- Sub-module `spram_bist_lfsr` contains the LFSR register with `load`/`advance` controls, the seed parameter and the zero-seed substitution.
- The FSM, compare pipeline and status registers stay in `spram_bist`.

## Test plan
Bench uses LAST_ADDR=3, SEED=16'hACE1 and a behavioural SPRAM model with 1-cycle read latency.
- Clean run, start at edge 0:
  - writes ACE1, E270, 7138, 389C to addresses 0..3;
  - `done`=1 at edge 10 with `pass`=1 and `err_count`=0.
- Model forces bit 0 of address 2 to 1:
  - `pass`=0, `fail_addr`=2, `err_count`=1.
- Faults at addresses 1 and 3:
  - `fail_addr`=1, `err_count`=2.
- `start` pulsed again at edge 5 while busy:
  - the pulse is ignored and timing is unchanged (`done` still at edge 10).
- `rst_n` low at edge 3 (mid-WRITE):
  - next edge gives IDLE with `ram_wren`=0 and all status outputs 0;
  - a later `start` produces a clean run.
- With `SPRAM_BIST_INV_PASS_EN`:
  - second-pass writes are 531E, 1D8F, 8EC7, C763;
  - `done` arrives at edge 20.
